// File: rtl/beam_delay_ctrl_if.sv
// Config handshake plus delay-select/status bundle between the beamformer control
// plane and beam_delay_ctrl.
interface beam_delay_ctrl_if #(
   parameter int NCH = 4,
   parameter int DW  = 2,
   parameter int CHW = 2
);
   logic                cfg_valid;
   logic                cfg_ready;
   logic [CHW-1:0]      cfg_ch;
   logic [DW-1:0]       cfg_delay;
   logic                cfg_last;
   logic                frame_start;
   logic [NCH*DW-1:0]   dly_sel;
   logic                dly_update;
   logic                out_valid;
   logic                busy;
   logic                cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_delay, cfg_last, frame_start,
      input  cfg_ready, dly_sel, dly_update, out_valid, busy, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_delay, cfg_last, frame_start,
      output cfg_ready, dly_sel, dly_update, out_valid, busy, cfg_err
   );
endinterface

// File: rtl/beam_delay_ctrl.sv
// Steering-delay controller: shadow table loaded over valid/ready, committed on the next
// frame strobe once armed (1-cycle latency); cfg_ready is low while armed or flushing.
module beam_delay_ctrl #(
   parameter int NCH   = 4,
   parameter int DW    = 2,
   parameter int CHW   = 2,
   parameter int FLUSH = 3
) (
   input  logic             clk,
   input  logic             rst,
   beam_delay_ctrl_if.slave bus
);
   localparam int CW = $clog2(FLUSH + 1);
   localparam logic [CHW:0] NCH_EXT = (CHW+1)'(NCH);

   typedef enum logic [1:0] {ST_RUN, ST_ARMED, ST_FLUSH} state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic                accept, commit, bad_ch;
   logic [NCH*DW-1:0]   shadow, active;
   logic                dly_update, out_valid, cfg_err;

   assign bad_ch = {1'b0, bus.cfg_ch} >= NCH_EXT;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_FLUSH;
         cnt   <= CW'(FLUSH);
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      commit    = 1'b0;
      case (state)
         ST_RUN: begin
            // frame_start is deliberately ignored here, even alongside the last beat
            accept = bus.cfg_valid;
            if (accept && bus.cfg_last)
               state_nxt = ST_ARMED;
         end
         ST_ARMED: begin
            if (bus.frame_start) begin
               commit    = 1'b1;
               cnt_nxt   = CW'(FLUSH);
               state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1))
               state_nxt = ST_RUN;
         end
         default: begin
            cnt_nxt   = CW'(FLUSH);
            state_nxt = ST_FLUSH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow     <= '0;
         active     <= '0;
         dly_update <= 1'b0;
         out_valid  <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (accept && ({1'b0, bus.cfg_ch} == (CHW+1)'(k)))
               shadow[k*DW +: DW] <= bus.cfg_delay;
         end
         if (accept && bad_ch)
            cfg_err <= 1'b1;
         if (commit)
            active <= shadow;
         dly_update <= commit;
         out_valid  <= (state_nxt != ST_FLUSH);
      end
   end

   assign bus.cfg_ready  = (state == ST_RUN);
   assign bus.busy       = (state != ST_RUN);
   assign bus.dly_sel    = active;
   assign bus.dly_update = dly_update;
   assign bus.out_valid  = out_valid;
   assign bus.cfg_err    = cfg_err;
endmodule

// File: tb/tb_beam_delay_ctrl.sv
// Bench for beam_delay_ctrl: directed scenarios with literal expectations, then random
// traffic compared every cycle against a table/counter model of the delay controller.
module tb_beam_delay_ctrl;
   localparam int NCH   = 4;
   localparam int DW    = 2;
   localparam int CHW   = 3;
   localparam int FLUSH = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   beam_delay_ctrl_if #(.NCH(NCH), .DW(DW), .CHW(CHW)) bus ();

   beam_delay_ctrl #(.NCH(NCH), .DW(DW), .CHW(CHW), .FLUSH(FLUSH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: tables plus "cycles of blanking left" and an armed flag.
   int m_shadow [NCH] = '{default: 0};
   int m_active [NCH] = '{default: 0};
   int m_blank        = FLUSH;
   bit m_armed        = 1'b0;
   bit m_err          = 1'b0;
   bit m_upd          = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NCH; k++) begin
            m_shadow[k] <= 0;
            m_active[k] <= 0;
         end
         m_blank <= FLUSH;
         m_armed <= 1'b0;
         m_err   <= 1'b0;
         m_upd   <= 1'b0;
      end else begin
         m_upd <= 1'b0;
         if (m_blank > 0) begin
            m_blank <= m_blank - 1;
         end else if (m_armed) begin
            if (bus.frame_start) begin
               for (int k = 0; k < NCH; k++) m_active[k] <= m_shadow[k];
               m_upd   <= 1'b1;
               m_blank <= FLUSH;
               m_armed <= 1'b0;
            end
         end else if (bus.cfg_valid) begin
            if (int'(bus.cfg_ch) < NCH) m_shadow[int'(bus.cfg_ch)] <= int'(bus.cfg_delay);
            else                        m_err <= 1'b1;
            if (bus.cfg_last) m_armed <= 1'b1;
         end
      end
   end

   logic [NCH*DW-1:0] exp_sel;
   logic              exp_ready;
   always_comb begin
      exp_sel = '0;
      for (int k = 0; k < NCH; k++) exp_sel[k*DW +: DW] = DW'(m_active[k]);
   end
   assign exp_ready = (m_blank == 0) && !m_armed;

   always @(negedge clk) begin
      chk("m_dly_sel",    32'(bus.dly_sel),    32'(exp_sel));
      chk("m_dly_update", 32'(bus.dly_update), 32'(m_upd));
      chk("m_out_valid",  32'(bus.out_valid),  32'(m_blank == 0));
      chk("m_cfg_ready",  32'(bus.cfg_ready),  32'(exp_ready));
      chk("m_busy",       32'(bus.busy),       32'(!exp_ready));
      chk("m_cfg_err",    32'(bus.cfg_err),    32'(m_err));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.cfg_valid   = 1'b0;
      bus.cfg_ch      = '0;
      bus.cfg_delay   = '0;
      bus.cfg_last    = 1'b0;
      bus.frame_start = 1'b0;
   endtask

   task automatic beat(input int ch, input int d, input bit last, input bit fs);
      int n = 0;
      while (!bus.cfg_ready && n < 40) begin
         step();
         n++;
      end
      if (!bus.cfg_ready) begin
         checks++;
         failures++;
         $display("FAIL beat_ready_timeout ch=%0d waited=%0d cycles", ch, n);
      end
      bus.cfg_valid   = 1'b1;
      bus.cfg_ch      = CHW'(ch);
      bus.cfg_delay   = DW'(d);
      bus.cfg_last    = last;
      bus.frame_start = fs;
      step();
      idle_in();
   endtask

   task automatic strobe();
      bus.frame_start = 1'b1;
      step();
      bus.frame_start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1);
   end

   initial begin
      idle_in();
      rst = 1'b1;
      repeat (3) step();

      // Reset release: three blanked cycles, then valid.
      rst = 1'b0;
      chk("t1_ov_c0", 32'(bus.out_valid), 32'd0);
      chk("t1_sel",   32'(bus.dly_sel),   32'd0);
      chk("t1_busy",  32'(bus.busy),      32'd1);
      step(); chk("t1_ov_c1", 32'(bus.out_valid), 32'd0);
      step(); chk("t1_ov_c2", 32'(bus.out_valid), 32'd0);
      step(); chk("t1_ov_c3", 32'(bus.out_valid), 32'd1);
      chk("t1_busy_low", 32'(bus.busy), 32'd0);

      // First set 1,2,3,0 committed five cycles after the last beat.
      beat(0, 1, 0, 0); beat(1, 2, 0, 0); beat(2, 3, 0, 0); beat(3, 0, 1, 0);
      chk("t2_armed_busy", 32'(bus.busy),    32'd1);
      chk("t2_armed_sel",  32'(bus.dly_sel), 32'd0);
      repeat (4) step();
      strobe();
      chk("t2_sel",   32'(bus.dly_sel),    32'h39);
      chk("t2_upd",   32'(bus.dly_update), 32'd1);
      chk("t2_ov_c0", 32'(bus.out_valid),  32'd0);
      step(); chk("t2_upd_off", 32'(bus.dly_update), 32'd0);
      chk("t2_ov_c1", 32'(bus.out_valid), 32'd0);
      step(); chk("t2_ov_c2", 32'(bus.out_valid), 32'd0);
      step(); chk("t2_ov_c3", 32'(bus.out_valid), 32'd1);

      // Last beat coincident with frame_start must not commit.
      beat(0, 2, 0, 0); beat(1, 0, 0, 0); beat(2, 1, 0, 0); beat(3, 3, 1, 1);
      step();
      chk("t3_no_commit_sel", 32'(bus.dly_sel),    32'h39);
      chk("t3_no_commit_upd", 32'(bus.dly_update), 32'd0);
      strobe();
      chk("t3_sel", 32'(bus.dly_sel),    32'hD2);
      chk("t3_upd", 32'(bus.dly_update), 32'd1);

      // Out-of-range channel sets the sticky error without touching the table.
      beat(5, 1, 0, 0);
      chk("t4_err", 32'(bus.cfg_err), 32'd1);
      step();
      chk("t4_err_sticky", 32'(bus.cfg_err), 32'd1);

      // Partial set: only ch2 rewritten.
      beat(2, 3, 1, 0);
      strobe();
      chk("t5_sel",    32'(bus.dly_sel), 32'hF2);
      chk("t5_err",    32'(bus.cfg_err), 32'd1);

      // Reset mid-flush and while armed.
      step();
      rst = 1'b1;
      #1;
      chk("t6_flush_sel", 32'(bus.dly_sel),   32'd0);
      chk("t6_flush_ov",  32'(bus.out_valid), 32'd0);
      chk("t6_flush_err", 32'(bus.cfg_err),   32'd0);
      step();
      rst = 1'b0;
      beat(1, 3, 1, 0);
      chk("t6_armed_ov", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("t6_armed_ov_rst", 32'(bus.out_valid), 32'd0);
      chk("t6_armed_busy",   32'(bus.busy),      32'd1);
      step();
      rst = 1'b0;
      step(); chk("t6_restart_c1", 32'(bus.out_valid), 32'd0);
      step(); chk("t6_restart_c2", 32'(bus.out_valid), 32'd0);
      step(); chk("t6_restart_c3", 32'(bus.out_valid), 32'd1);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         bus.cfg_valid   = 1'($urandom_range(0, 1));
         bus.cfg_ch      = ($urandom_range(0, 15) == 0) ? CHW'($urandom_range(4, 7))
                                                        : CHW'($urandom_range(0, 3));
         bus.cfg_delay   = DW'($urandom_range(0, (1 << DW) - 1));
         bus.cfg_last    = ($urandom_range(0, 3) == 0);
         bus.frame_start = ($urandom_range(0, 5) == 0);
         rst             = ($urandom_range(0, 399) == 0);
         step();
      end
      rst = 1'b0;
      idle_in();
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
